// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: core-side instruction stream and memory-side read bus of the prefetcher.
interface instr_prefetch_if;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        instr_ready;
  logic [15:0] instruction;
  logic [15:0] instr_addr;
  logic        instr_valid;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] flush_count;
  modport master (
    input  redirect, redirect_addr, instr_ready, mem_ack, mem_rdata,
    output instruction, instr_addr, instr_valid, mem_req, mem_addr, flush_count
  );
  modport slave (
    output redirect, redirect_addr, instr_ready, mem_ack, mem_rdata,
    input  instruction, instr_addr, instr_valid, mem_req, mem_addr, flush_count
  );
endinterface

// File: rtl/instr_prefetch.sv
// instr_prefetch: DEPTH-entry (2 or 4) instruction prefetch FIFO with redirect/flush handling.
// Define INSTR_PREFETCH_STATS_EN to enable the saturating flush counter.
module instr_prefetch #(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic reset,
  instr_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state;
  logic [15:0] data_q [DEPTH];
  logic [15:0] addr_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, count_n;
  logic [15:0] next_fetch, fetch_addr, inc;
  logic req, hit, miss, pop, push;
  assign bus.instr_valid = count != '0;
  assign bus.instruction = data_q[rd_ptr];
  assign bus.instr_addr  = addr_q[rd_ptr];
  assign bus.mem_req     = req;
  assign bus.mem_addr    = fetch_addr;
  always_comb begin
    hit     = bus.redirect && bus.instr_valid && bus.instr_addr == bus.redirect_addr;
    miss    = bus.redirect && !hit;
    pop     = bus.instr_valid && bus.instr_ready && !miss;
    push    = state == FETCH && bus.mem_ack && !miss;
    count_n = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    inc     = fetch_addr + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req        <= 1'b0;
      fetch_addr <= '0;
      next_fetch <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      if (push) begin
        data_q[wr_ptr] <= bus.mem_rdata;
        addr_q[wr_ptr] <= fetch_addr;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      if (miss) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        next_fetch <= bus.redirect_addr;
      end
      case (state)
        IDLE: if (!bus.redirect && count < FULL) begin
          state      <= FETCH;
          req        <= 1'b1;
          fetch_addr <= next_fetch;
        end
        FETCH: if (miss) begin
          state <= bus.mem_ack ? IDLE : DRAIN;
          req   <= !bus.mem_ack;
        end else if (bus.mem_ack) begin
          next_fetch <= inc;
          if (count_n < FULL) fetch_addr <= inc;
          else begin
            state <= IDLE;
            req   <= 1'b0;
          end
        end
        DRAIN: if (bus.mem_ack) begin
          state <= IDLE;
          req   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end
`ifdef INSTR_PREFETCH_STATS_EN
  logic [15:0] flushes;
  always_ff @(posedge clk) begin
    if (reset) flushes <= '0;
    else if (miss && flushes != 16'hFFFF) flushes <= flushes + 16'd1;
  end
  assign bus.flush_count = flushes;
`else
  assign bus.flush_count = 16'h0000;
`endif
endmodule
